// File: rtl/myadd_serial_if.sv
// Operand/result bundle for myadd_serial: launch request, operands and the
// registered result with its status flags.
interface myadd_serial_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Controller side: issues operations, reads results
    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, ovf
    );

    // Adder side
    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/myadd_serial.sv
// myadd_serial: digit-serial adder/subtractor. DIGIT bits of the WIDTH-bit
// operands are added per clock, low digit first. Subtraction is done as
// a + ~b + ~cin, so cout reads as "no borrow" in subtract mode.
// WIDTH must be a multiple of DIGIT.
module myadd_serial #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic          clk,
    input  logic          rst,
    myadd_serial_if.slave bus
);
    localparam int unsigned   N       = WIDTH / DIGIT;
    localparam int unsigned   CW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CntLast = CW'(N - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;      // operand A, shifted right one digit per RUN cycle
    logic [WIDTH-1:0] r_b;      // operand B' (already inverted for subtract)
    logic [WIDTH-1:0] r_res;    // partial result, digits enter at the top
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [DIGIT-1:0] w_dsum;
    logic [DIGIT:0]   w_c;      // w_c[i] is the carry into bit i of the current digit
    logic [WIDTH-1:0] w_res_next;

    // Ripple add of the current low digit plus the carry register
    always_comb begin
        w_c    = '0;
        w_dsum = '0;
        w_c[0] = r_carry;
        for (int i = 0; i < DIGIT; i++) begin
            w_dsum[i]  = r_a[i] ^ r_b[i] ^ w_c[i];
            w_c[i + 1] = (r_a[i] & r_b[i]) | (r_a[i] & w_c[i]) | (r_b[i] & w_c[i]);
        end
        w_res_next = (r_res >> DIGIT) | (WIDTH'(w_dsum) << (WIDTH - DIGIT));
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                // DONE accepts a new launch exactly like IDLE, giving back-to-back ops
                StIdle, StDone: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.sub ? ~bus.b : bus.b;
                        r_carry <= bus.sub ? ~bus.cin : bus.cin;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StRun;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                StRun: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_res   <= w_res_next;
                    r_carry <= w_c[DIGIT];
                    if (r_cnt == CntLast) begin
                        // Top digit: its internal carries give carry-in/out of the MSB
                        r_sum   <= w_res_next;
                        r_cout  <= w_c[DIGIT];
                        r_ovf   <= w_c[DIGIT] ^ w_c[DIGIT - 1];
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_myadd_serial.sv
// Bench for myadd_serial: three instances (8/2, 16/16, 16/4). Stimulus pushes
// the model's expected result into a per-instance queue; monitors pop on done.
module tb_myadd_serial;
    localparam int N8 = 4;
    localparam int NA = 1;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Edge counter used to measure launch-to-done latency
    always @(posedge clk) cyc <= cyc + 1;

    myadd_serial_if #(.WIDTH(8))  bus8 ();
    myadd_serial_if #(.WIDTH(16)) bus16a ();
    myadd_serial_if #(.WIDTH(16)) bus16b ();

    myadd_serial #(.WIDTH(8), .DIGIT(2)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    myadd_serial #(.WIDTH(16), .DIGIT(16)) u_dut16a (
        .clk (clk),
        .rst (rst),
        .bus (bus16a)
    );

    myadd_serial #(.WIDTH(16), .DIGIT(4)) u_dut16b (
        .clk (clk),
        .rst (rst),
        .bus (bus16b)
    );

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t q8[$];
    exp_t qa[$];
    exp_t qb[$];

    int n_chk  = 0;
    int n_pass = 0;
    int run8   = 0;
    int runa   = 0;
    int runb   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Reference: unsigned and signed integer arithmetic on the operand values
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub, input int acc);
        exp_t   e;
        longint m, half, ua, ub, sa, sb, ci, u, r;
        m    = longint'(1) << w;
        half = m >> 1;
        ua   = longint'(a) & (m - 1);
        ub   = longint'(b) & (m - 1);
        ci   = cin ? 1 : 0;
        sa   = (ua >= half) ? ua - m : ua;
        sb   = (ub >= half) ? ub - m : ub;
        if (sub) begin
            u      = ua - ub - ci;
            r      = sa - sb - ci;
            e.cout = (ua >= ub + ci);
        end else begin
            u      = ua + ub + ci;
            r      = sa + sb + ci;
            e.cout = (u >= m);
        end
        if (u < 0) u = u + m;
        if (u >= m) u = u - m;
        e.sum = 16'(u);
        e.ovf = (r < -half) || (r >= half);
        e.acc = acc;
        return e;
    endfunction

    // Called just after a negedge with the 8-bit DUT idle or in DONE.
    // Returns at the negedge of the DONE cycle, so a following call is back-to-back.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sub);
        bus8.a     = a;
        bus8.b     = b;
        bus8.cin   = cin;
        bus8.sub   = sub;
        bus8.start = 1'b1;
        q8.push_back(model(8, {8'h00, a}, {8'h00, b}, cin, sub, cyc + 1));
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        // RUN cycles: stray starts and changing operands must be ignored
        for (int j = 0; j < N8; j++) begin
            @(negedge clk);
            bus8.start = 1'($urandom_range(0, 1));
            bus8.a     = 8'($urandom);
            bus8.b     = 8'($urandom);
            bus8.cin   = 1'($urandom_range(0, 1));
            bus8.sub   = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        bus8.start = 1'b0;
    endtask

    task automatic idle8(input int n);
        bus8.start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Both 16-bit instances get the same op; returns at the DIGIT=4 DONE negedge
    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub);
        bus16a.a = a; bus16a.b = b; bus16a.cin = cin; bus16a.sub = sub;
        bus16b.a = a; bus16b.b = b; bus16b.cin = cin; bus16b.sub = sub;
        bus16a.start = 1'b1;
        bus16b.start = 1'b1;
        qa.push_back(model(16, a, b, cin, sub, cyc + 1));
        qb.push_back(model(16, a, b, cin, sub, cyc + 1));
        @(posedge clk);
        #1;
        bus16a.start = 1'b0;
        bus16b.start = 1'b0;
        bus16a.a = 16'($urandom); bus16a.b = 16'($urandom);
        bus16b.a = 16'($urandom); bus16b.b = 16'($urandom);
        repeat (NB + 1) @(negedge clk);
    endtask

    // Monitor: 8-bit instance
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            run8 = 0;
        end else begin
            if (bus8.busy) run8++;
            if (bus8.done) begin
                if (q8.size() == 0) begin
                    chk("done8_unexpected", bus8.done, 1'b0);
                end else begin
                    e = q8.pop_front();
                    chk("sum8", bus8.sum, e.sum);
                    chk("cout8", bus8.cout, e.cout);
                    chk("ovf8", bus8.ovf, e.ovf);
                    chk("latency8", cyc - e.acc, N8);
                    chk("busy_cycles8", run8, N8);
                end
                run8 = 0;
            end
        end
    end

    // Monitor: 16-bit, DIGIT=16
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            runa = 0;
        end else begin
            if (bus16a.busy) runa++;
            if (bus16a.done) begin
                if (qa.size() == 0) begin
                    chk("done16a_unexpected", bus16a.done, 1'b0);
                end else begin
                    e = qa.pop_front();
                    chk("sum16a", bus16a.sum, e.sum);
                    chk("cout16a", bus16a.cout, e.cout);
                    chk("ovf16a", bus16a.ovf, e.ovf);
                    chk("latency16a", cyc - e.acc, NA);
                    chk("busy_cycles16a", runa, NA);
                end
                runa = 0;
            end
        end
    end

    // Monitor: 16-bit, DIGIT=4
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            runb = 0;
        end else begin
            if (bus16b.busy) runb++;
            if (bus16b.done) begin
                if (qb.size() == 0) begin
                    chk("done16b_unexpected", bus16b.done, 1'b0);
                end else begin
                    e = qb.pop_front();
                    chk("sum16b", bus16b.sum, e.sum);
                    chk("cout16b", bus16b.cout, e.cout);
                    chk("ovf16b", bus16b.ovf, e.ovf);
                    chk("latency16b", cyc - e.acc, NB);
                    chk("busy_cycles16b", runb, NB);
                end
                runb = 0;
            end
        end
    end

    // Hard stop if the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus8.start = 1'b0;   bus8.a = '0;   bus8.b = '0;   bus8.cin = 1'b0;   bus8.sub = 1'b0;
        bus16a.start = 1'b0; bus16a.a = '0; bus16a.b = '0; bus16a.cin = 1'b0; bus16a.sub = 1'b0;
        bus16b.start = 1'b0; bus16b.a = '0; bus16b.b = '0; bus16b.cin = 1'b0; bus16b.sub = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus8.busy, 1'b0);
        chk("rst_done", bus8.done, 1'b0);
        chk("rst_sum", bus8.sum, 8'd0);
        chk("rst_cout", bus8.cout, 1'b0);
        chk("rst_ovf", bus8.ovf, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Directed 8-bit cases, mixing idle gaps and back-to-back launches
        op8(8'd255, 8'd255, 1'b0, 1'b0);
        idle8(2);
        op8(8'd99, 8'd77, 1'b1, 1'b0);
        op8(8'd123, 8'd246, 1'b1, 1'b0);
        idle8(1);
        op8(8'd14, 8'd88, 1'b0, 1'b1);
        op8(8'd88, 8'd14, 1'b0, 1'b1);
        op8(8'd150, 8'd44, 1'b0, 1'b0);
        op8(8'd128, 8'd1, 1'b0, 1'b1);
        op8(8'd127, 8'd0, 1'b1, 1'b0);
        idle8(3);

        // Random 8-bit operations
        for (int i = 0; i < 40; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle8($urandom_range(0, 3));
        end
        idle8(2);

        // Reset during the second RUN cycle: aborted op must never complete
        bus8.a = 8'd200; bus8.b = 8'd100; bus8.cin = 1'b1; bus8.sub = 1'b0;
        bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", bus8.busy, 1'b0);
        chk("abort_done", bus8.done, 1'b0);
        chk("abort_sum", bus8.sum, 8'd0);
        chk("abort_cout", bus8.cout, 1'b0);
        chk("abort_ovf", bus8.ovf, 1'b0);
        rst = 1'b0;
        idle8(10);
        op8(8'd1, 8'd2, 1'b0, 1'b0);
        idle8(2);

        // 16-bit sweep on DIGIT=16 and DIGIT=4
        op16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        op16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        op16(16'h8000, 16'h0001, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            op16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        repeat (10) @(negedge clk);
        chk("drain8", q8.size(), 0);
        chk("drain16a", qa.size(), 0);
        chk("drain16b", qb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
